hmmm_datapath: RTL and testbench

//  8-bit datapath of the HMMM-style microprocessor. Holds PC, instruction low byte, 8x8 register file,
//  ALU and memory address/data muxing. Sits beside the controller inside top; drives the SRAM address
//  and the low byte of the shared 16-bit bidirectional memory bus. All control comes from the controller.

---
 rtl/hmmm_pkg.sv | 18 +
 rtl/hmmm_regfile.sv | 35 +++
 rtl/hmmm_datapath.sv | 107 ++++++++++
 tb/tb_hmmm_datapath.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hmmm_pkg.sv
// Shared constants and mux encodings for the HMMM-style 8-bit datapath.
package hmmm_pkg;

    localparam int WIDTH = 8;
    localparam int NREGS = 8;
    localparam int RA_W  = $clog2(NREGS);

    // PCSrc: 11 is treated the same as 10.
    localparam logic [1:0] PC_PLUS1 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_REG   = 2'b10;

    // RegWriteSrc: 11 is treated the same as 10.
    localparam logic [1:0] WD_IMM = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_ALU = 2'b10;

endpackage

// File: rtl/hmmm_regfile.sv
// 8x8 register file, two combinational read ports and one clocked write port.
// r0 always reads as zero and ignores writes.
module hmmm_regfile
    import hmmm_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [RA_W-1:0]  ra1,
    input  logic [RA_W-1:0]  ra2,
    input  logic [RA_W-1:0]  wa3,
    input  logic             we3,
    input  logic [WIDTH-1:0] wd3,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] regs [NREGS];

    // NOTE: this array is deliberately reset, so it maps to flops rather than a RAM macro;
    // software relies on every register reading zero after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we3 && (wa3 != '0)) begin
            regs[wa3] <= wd3;
        end
    end

    // A read of the register being written returns the old value until the edge.
    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/hmmm_datapath.sv
// Datapath of the HMMM-style processor: PC, instruction byte, register file, ALU,
// write-back muxing and the low byte of the shared memory bus.
module hmmm_datapath
    import hmmm_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    output logic [WIDTH-1:0] Adr,
    output logic             negative,
    output logic             zero,
    inout  wire  [WIDTH-1:0] MemData,
    input  logic             ALUSub,
    input  logic             AdrSrc,
    input  logic [RA_W-1:0]  instr1,
    input  logic             InstrSrc,
    input  logic             MemWrite,
    input  logic             PCEnable,
    input  logic [1:0]       PCSrc,
    input  logic             RA1Src,
    input  logic             RegWLoadSrc,
    input  logic             RegWrite,
    input  logic [1:0]       RegWriteSrc,
    input  logic             TwoRegs
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] instr_reg;
    logic [WIDTH-1:0] instr2;
    logic [WIDTH-1:0] imm;
    logic [RA_W-1:0]  ra1;
    logic [RA_W-1:0]  ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] wd3_temp;
    logic [WIDTH-1:0] wd3_reg;
    logic [WIDTH-1:0] wd3;

    // Instruction byte: the live bus during fetch, the captured copy afterwards.
    assign instr2 = InstrSrc ? MemData : instr_reg;
    assign imm    = instr2;
    assign ra1    = RA1Src ? instr1 : instr2[7:5];
    assign ra2    = instr2[4:2];

    hmmm_regfile u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .ra1     (ra1),
        .ra2     (ra2),
        .wa3     (instr1),
        .we3     (RegWrite),
        .wd3     (wd3),
        .rd1     (rd1),
        .rd2     (rd2)
    );

    // Subtraction is SrcA + ~SrcB + 1; the carry out is dropped.
    assign src_a  = TwoRegs ? rd1 : '0;
    assign src_b  = rd2 ^ {WIDTH{ALUSub}};
    assign result = src_a + src_b + {{(WIDTH-1){1'b0}}, ALUSub};

    // NOTE: every always_comb output gets a default before the case, so no latch can be inferred.
    always_comb begin
        wd3_temp = result;
        case (RegWriteSrc)
            WD_IMM:  wd3_temp = imm;
            WD_MEM:  wd3_temp = MemData;
            default: wd3_temp = result;
        endcase
    end

    // Two-cycle ops write the value latched in their first cycle; loads write the live bus.
    assign wd3 = RegWLoadSrc ? wd3_temp : wd3_reg;

    always_comb begin
        pc_next = pc + WIDTH'(1);
        case (PCSrc)
            PC_PLUS1: pc_next = pc + WIDTH'(1);
            PC_IMM:   pc_next = imm;
            default:  pc_next = rd1;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= '0;
            instr_reg <= '0;
            wd3_reg   <= '0;
        end else begin
            instr_reg <= MemData;
            wd3_reg   <= wd3_temp;
            if (PCEnable) begin
                pc <= pc_next;
            end
        end
    end

    assign Adr      = AdrSrc ? rd2 : pc;
    assign negative = rd1[WIDTH-1];
    assign zero     = (rd1 == '0);
    assign MemData  = MemWrite ? rd1 : 'z;

endmodule

// File: tb/tb_hmmm_datapath.sv
// Directed scenarios plus randomized cycles checked against a behavioural model of the datapath.
module tb_hmmm_datapath;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] Adr;
    logic       negative;
    logic       zero;
    wire  [7:0] MemData;
    logic       ALUSub, AdrSrc, InstrSrc, MemWrite, PCEnable, RA1Src;
    logic       RegWLoadSrc, RegWrite, TwoRegs;
    logic [2:0] instr1;
    logic [1:0] PCSrc, RegWriteSrc;

    logic       bus_en;
    logic [7:0] bus_drv;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model state
    int m_regs [8];
    int m_pc, m_instr, m_wd3;
    int c_rd1, c_rd2, c_bus, c_live, c_instr;

    always #5 clk = ~clk;

    assign MemData = (bus_en && !MemWrite) ? bus_drv : 8'bz;

    hmmm_datapath dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .Adr         (Adr),
        .negative    (negative),
        .zero        (zero),
        .MemData     (MemData),
        .ALUSub      (ALUSub),
        .AdrSrc      (AdrSrc),
        .instr1      (instr1),
        .InstrSrc    (InstrSrc),
        .MemWrite    (MemWrite),
        .PCEnable    (PCEnable),
        .PCSrc       (PCSrc),
        .RA1Src      (RA1Src),
        .RegWLoadSrc (RegWLoadSrc),
        .RegWrite    (RegWrite),
        .RegWriteSrc (RegWriteSrc),
        .TwoRegs     (TwoRegs)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_pc = 0; m_instr = 0; m_wd3 = 0;
    endtask

    task automatic idle_inputs();
        ALUSub = 0; AdrSrc = 0; InstrSrc = 0; MemWrite = 0; PCEnable = 0; RA1Src = 0;
        RegWLoadSrc = 0; RegWrite = 0; TwoRegs = 0; instr1 = 0; PCSrc = 0; RegWriteSrc = 0;
    endtask

    // Evaluate the combinational view of the processor from the architectural rules.
    task automatic model_eval();
        int ra1, ra2, res;
        c_instr = InstrSrc ? int'(bus_drv) : m_instr;
        ra1 = RA1Src ? int'(instr1) : c_instr / 32;
        ra2 = (c_instr / 4) % 8;
        c_rd1 = m_regs[ra1];
        c_rd2 = m_regs[ra2];
        c_bus = MemWrite ? c_rd1 : int'(bus_drv);
        if (ALUSub) res = ((TwoRegs ? c_rd1 : 0) - c_rd2 + 256) % 256;
        else        res = ((TwoRegs ? c_rd1 : 0) + c_rd2) % 256;
        case (RegWriteSrc)
            2'b00:   c_live = c_instr;
            2'b01:   c_live = c_bus;
            default: c_live = res;
        endcase
    endtask

    task automatic model_commit();
        if (RegWrite && instr1 != 0) m_regs[instr1] = RegWLoadSrc ? c_live : m_wd3;
        m_wd3   = c_live;
        m_instr = c_bus;
        if (PCEnable) begin
            case (PCSrc)
                2'b00:   m_pc = (m_pc + 1) % 256;
                2'b01:   m_pc = c_instr;
                default: m_pc = c_rd1;
            endcase
        end
    endtask

    // Called just after a negedge with inputs applied; compares, clocks once, returns at the next negedge.
    task automatic step();
        #1;
        model_eval();
        check("adr", Adr, AdrSrc ? c_rd2 : m_pc);
        check("zero", zero, c_rd1 == 0);
        check("negative", negative, c_rd1 >= 128);
        if (MemWrite) check("memdata_out", MemData, c_rd1);
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic load_reg(input logic [2:0] r, input logic [7:0] v);
        idle_inputs();
        InstrSrc = 1; bus_drv = v; RegWriteSrc = 2'b00; RegWLoadSrc = 1; instr1 = r; RegWrite = 1;
        step();
    endtask

    initial begin
        idle_inputs();
        bus_en = 0; bus_drv = 8'h00;
        reset_n = 0;
        model_reset();

        // Reset state
        #2;
        check("rst_adr", Adr, 8'h00);
        check("rst_memdata_z", MemData === 8'bz, 1'b1);
        check("rst_zero", zero, 1'b1);
        @(negedge clk);
        bus_en = 1;
        reset_n = 1;

        // PC increments and wraps
        idle_inputs(); PCEnable = 1; PCSrc = 2'b00;
        repeat (3) step();
        #1 check("pc_plus3", Adr, 8'h03);
        PCSrc = 2'b01; InstrSrc = 1; bus_drv = 8'hFF;
        step();
        #1 check("pc_ff", Adr, 8'hFF);
        PCSrc = 2'b00; InstrSrc = 0;
        step();
        #1 check("pc_wrap", Adr, 8'h00);

        // Immediate load into r1
        load_reg(3'd1, 8'h2D);
        idle_inputs(); RA1Src = 1; instr1 = 1;
        #1 check("r1_zero", zero, 1'b0);
        check("r1_neg", negative, 1'b0);

        // Two-cycle subtract r3 = r1 - r2
        load_reg(3'd2, 8'h07);
        load_reg(3'd1, 8'h05);
        idle_inputs(); InstrSrc = 1; bus_drv = 8'h28; TwoRegs = 1; ALUSub = 1; RegWriteSrc = 2'b10;
        step();
        idle_inputs(); bus_drv = 8'h00; RegWLoadSrc = 0; instr1 = 3; RegWrite = 1;
        step();
        idle_inputs(); RA1Src = 1; instr1 = 3;
        #1 check("sub_neg", negative, 1'b1);
        check("sub_zero", zero, 1'b0);
        step();

        // Store drive and register-addressed memory
        load_reg(3'd1, 8'h2D);
        idle_inputs(); bus_drv = 8'h08;
        step();
        idle_inputs(); MemWrite = 1; RA1Src = 1; instr1 = 1; AdrSrc = 1;
        #1 check("store_data", MemData, 8'h2D);
        check("adr_rd2", Adr, 8'h07);
        step();

        // Jumps and r0
        idle_inputs(); PCSrc = 2'b01; InstrSrc = 1; bus_drv = 8'h20; PCEnable = 1;
        step();
        #1 check("jump_imm", Adr, 8'h20);
        idle_inputs(); PCSrc = 2'b10; RA1Src = 1; instr1 = 1; PCEnable = 1;
        step();
        #1 check("jump_reg", Adr, 8'h2D);
        load_reg(3'd0, 8'h55);
        idle_inputs(); RA1Src = 1; instr1 = 0;
        #1 check("r0_zero", zero, 1'b1);
        step();

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            MemWrite    = ($urandom_range(3) == 0);
            InstrSrc    = MemWrite ? 1'b0 : 1'($urandom_range(1));
            bus_drv     = 8'($urandom);
            ALUSub      = 1'($urandom_range(1));
            AdrSrc      = 1'($urandom_range(1));
            PCEnable    = 1'($urandom_range(1));
            RA1Src      = 1'($urandom_range(1));
            RegWLoadSrc = 1'($urandom_range(1));
            RegWrite    = ($urandom_range(3) != 0);
            TwoRegs     = 1'($urandom_range(1));
            instr1      = 3'($urandom);
            PCSrc       = 2'($urandom);
            RegWriteSrc = 2'($urandom);
            step();
        end

        // Asynchronous reset in mid-operation
        idle_inputs(); RegWrite = 1; RegWLoadSrc = 1; instr1 = 5; InstrSrc = 1; bus_drv = 8'h99;
        PCEnable = 1; PCSrc = 2'b01;
        #2 reset_n = 0;
        #1 check("async_rst_adr", Adr, 8'h00);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        idle_inputs(); RA1Src = 1;
        for (int i = 1; i < 8; i++) begin
            instr1 = 3'(i);
            #1 check("rst_reg_zero", zero, 1'b1);
        end
        @(negedge clk);
        load_reg(3'd6, 8'h81);
        idle_inputs(); RA1Src = 1; instr1 = 6;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
